// File: rtl/dqn_td_target_unit_pkg.sv
// Shared FP32 constants, operand classification and the final round/pack step
// used by both the multiply and the add halves of the TD-target datapath.
package dqn_td_target_unit_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS = 127;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] FP_POS_ZERO = 32'h00000000;
  localparam logic [31:0] GAMMA_DEFAULT = 32'h3F4CCCCD;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Denormals classify as zero, so they never reach the mantissa datapath.
  function automatic fp_class_e fp_classify(input logic [31:0] x);
    if (x[30:23] == 8'hFF) begin
      return (x[22:0] == 23'd0) ? FP_INF : FP_NAN;
    end else if (x[30:23] == 8'h00) begin
      return FP_ZERO;
    end
    return FP_NORM;
  endfunction

  // Round a normalised 24-bit mantissa (leading one at bit 23) to nearest-even,
  // then saturate to infinity or flush to signed zero when the biased exponent
  // leaves the normal range.
  function automatic logic [31:0] fp_round_pack(
    input logic              sign,
    input logic signed [9:0] exp,
    input logic [23:0]       mant,
    input logic              guard,
    input logic              sticky
  );
    logic [24:0]       m_r;
    logic signed [9:0] e_r;
    m_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    e_r = exp;
    if (m_r[24]) begin
      m_r = m_r >> 1;
      e_r = exp + 10'sd1;
    end
    if (e_r >= 10'sd255) begin
      return {sign, 8'hFF, 23'd0};
    end else if (e_r <= 10'sd0) begin
      return {sign, 31'd0};
    end
    return {sign, e_r[7:0], m_r[22:0]};
  endfunction

endpackage

// File: rtl/dqn_td_target_unit_fp32_mul_add.sv
// Four-stage unfused FP32 a*b + c: stages 1-2 multiply and round the product,
// stages 3-4 align, add and round the sum. One operation accepted per cycle.
module fp32_mul_add
  import dqn_td_target_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  output logic        o_valid,
  output logic [31:0] o_result
);

  // stage 1 registers: raw product and special-case shortcut
  logic              r_s1_valid;
  logic              r_s1_sign;
  logic signed [9:0] r_s1_exp;
  logic [47:0]       r_s1_prod;
  logic              r_s1_special;
  logic [31:0]       r_s1_special_val;
  logic [31:0]       r_s1_c;
  // stage 2 registers: rounded product
  logic              r_s2_valid;
  logic [31:0]       r_s2_p;
  logic [31:0]       r_s2_c;
  // stage 3 registers: aligned addends
  logic              r_s3_valid;
  logic              r_s3_special;
  logic [31:0]       r_s3_special_val;
  logic              r_s3_sign;
  logic signed [9:0] r_s3_exp;
  logic [26:0]       r_s3_big;
  logic [26:0]       r_s3_small;
  logic              r_s3_eff_sub;
  // stage 4 registers: final result
  logic              r_s4_valid;
  logic [31:0]       r_s4_result;

  fp_class_e         w_a_cls, w_b_cls;
  logic              w_m_sign;
  logic              w_m_special;
  logic [31:0]       w_m_special_val;
  logic signed [9:0] w_m_exp;
  logic [47:0]       w_m_prod;

  // Multiply: exponent sum, 24x24 mantissa product, IEEE special cases
  always_comb begin
    w_a_cls = fp_classify(i_a);
    w_b_cls = fp_classify(i_b);
    w_m_sign = i_a[31] ^ i_b[31];
    w_m_special = 1'b1;
    w_m_special_val = {w_m_sign, 31'd0};
    w_m_exp = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]}) - 10'sd127;
    w_m_prod = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
    if (w_a_cls == FP_NAN || w_b_cls == FP_NAN) begin
      w_m_special_val = FP_CANON_NAN;
    end else if (w_a_cls == FP_INF || w_b_cls == FP_INF) begin
      w_m_special_val = (w_a_cls == FP_ZERO || w_b_cls == FP_ZERO) ?
                        FP_CANON_NAN : {w_m_sign, 8'hFF, 23'd0};
    end else if (w_a_cls == FP_ZERO || w_b_cls == FP_ZERO) begin
      w_m_special_val = {w_m_sign, 31'd0};
    end else begin
      w_m_special = 1'b0;
    end
  end

  logic [23:0]       w_p_mant;
  logic              w_p_guard;
  logic              w_p_sticky;
  logic signed [9:0] w_p_exp;
  logic [31:0]       w_p;

  // Product normalise: the product of two [1,2) mantissas lies in [1,4)
  always_comb begin
    if (r_s1_prod[47]) begin
      w_p_mant = r_s1_prod[47:24];
      w_p_guard = r_s1_prod[23];
      w_p_sticky = |r_s1_prod[22:0];
      w_p_exp = r_s1_exp + 10'sd1;
    end else begin
      w_p_mant = r_s1_prod[46:23];
      w_p_guard = r_s1_prod[22];
      w_p_sticky = |r_s1_prod[21:0];
      w_p_exp = r_s1_exp;
    end
    w_p = r_s1_special ? r_s1_special_val :
          fp_round_pack(r_s1_sign, w_p_exp, w_p_mant, w_p_guard, w_p_sticky);
  end

  fp_class_e   w_p_cls, w_c_cls;
  logic        w_p_ge;
  logic [31:0] w_big, w_small;
  logic [7:0]  w_diff;
  logic [49:0] w_wide;
  logic        w_a_special;
  logic [31:0] w_a_special_val;

  // Add alignment: order by magnitude, shift the smaller with guard/round/sticky
  always_comb begin
    w_p_cls = fp_classify(r_s2_p);
    w_c_cls = fp_classify(r_s2_c);
    w_p_ge = (r_s2_p[30:0] >= r_s2_c[30:0]);
    w_big = w_p_ge ? r_s2_p : r_s2_c;
    w_small = w_p_ge ? r_s2_c : r_s2_p;
    w_diff = w_big[30:23] - w_small[30:23];
    w_wide = {1'b1, w_small[22:0], 26'd0} >> w_diff;
    w_a_special = 1'b1;
    w_a_special_val = FP_CANON_NAN;
    if (w_p_cls == FP_NAN || w_c_cls == FP_NAN) begin
      w_a_special_val = FP_CANON_NAN;
    end else if (w_p_cls == FP_INF && w_c_cls == FP_INF) begin
      w_a_special_val = (r_s2_p[31] == r_s2_c[31]) ? r_s2_p : FP_CANON_NAN;
    end else if (w_p_cls == FP_INF) begin
      w_a_special_val = r_s2_p;
    end else if (w_c_cls == FP_INF) begin
      w_a_special_val = r_s2_c;
    end else if (w_p_cls == FP_ZERO && w_c_cls == FP_ZERO) begin
      w_a_special_val = {r_s2_p[31] & r_s2_c[31], 31'd0};
    end else if (w_p_cls == FP_ZERO) begin
      w_a_special_val = r_s2_c;
    end else if (w_c_cls == FP_ZERO) begin
      w_a_special_val = r_s2_p;
    end else begin
      w_a_special = 1'b0;
    end
  end

  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic              w_lz_found;
  logic [26:0]       w_norm;
  logic [31:0]       w_result;

  // Add/normalise/round; exact cancellation yields +0
  always_comb begin
    w_sum = r_s3_eff_sub ? ({1'b0, r_s3_big} - {1'b0, r_s3_small}) :
                           ({1'b0, r_s3_big} + {1'b0, r_s3_small});
    w_lz = 5'd0;
    w_lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!w_lz_found && w_sum[i]) begin
        w_lz_found = 1'b1;
        w_lz = 5'(26 - i);
      end
    end
    w_norm = w_sum[26:0] << w_lz;
    if (r_s3_special) begin
      w_result = r_s3_special_val;
    end else if (w_sum == 28'd0) begin
      w_result = FP_POS_ZERO;
    end else if (w_sum[27]) begin
      w_result = fp_round_pack(r_s3_sign, r_s3_exp + 10'sd1, w_sum[27:4], w_sum[3], |w_sum[2:0]);
    end else begin
      w_result = fp_round_pack(r_s3_sign, r_s3_exp - $signed({5'd0, w_lz}),
                               w_norm[26:3], w_norm[2], |w_norm[1:0]);
    end
  end

  // Pipeline registers; the output word only changes on a valid result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_exp <= '0;
      r_s1_prod <= '0;
      r_s1_special <= 1'b0;
      r_s1_special_val <= '0;
      r_s1_c <= '0;
      r_s2_valid <= 1'b0;
      r_s2_p <= '0;
      r_s2_c <= '0;
      r_s3_valid <= 1'b0;
      r_s3_special <= 1'b0;
      r_s3_special_val <= '0;
      r_s3_sign <= 1'b0;
      r_s3_exp <= '0;
      r_s3_big <= '0;
      r_s3_small <= '0;
      r_s3_eff_sub <= 1'b0;
      r_s4_valid <= 1'b0;
      r_s4_result <= '0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_sign <= w_m_sign;
      r_s1_exp <= w_m_exp;
      r_s1_prod <= w_m_prod;
      r_s1_special <= w_m_special;
      r_s1_special_val <= w_m_special_val;
      r_s1_c <= i_c;
      r_s2_valid <= r_s1_valid;
      r_s2_p <= w_p;
      r_s2_c <= r_s1_c;
      r_s3_valid <= r_s2_valid;
      r_s3_special <= w_a_special;
      r_s3_special_val <= w_a_special_val;
      r_s3_sign <= w_big[31];
      r_s3_exp <= $signed({2'b00, w_big[30:23]});
      r_s3_big <= {1'b1, w_big[22:0], 3'b000};
      r_s3_small <= {w_wide[49:24], (|w_wide[23:0]) | (w_diff > 8'd49)};
      r_s3_eff_sub <= r_s2_p[31] ^ r_s2_c[31];
      r_s4_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_s4_result <= w_result;
      end
    end
  end

  assign o_valid = r_s4_valid;
  assign o_result = r_s4_result;

endmodule

// File: rtl/dqn_td_target_unit.sv
// DQN TD-target stage: latches reward/done, and on each target-net Q-max
// strobe produces y = done ? reward : reward + GAMMA*q_max four cycles later.
module dqn_td_target_unit
  import dqn_td_target_unit_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] GAMMA = GAMMA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_q_max_valid,
  input  logic [DATA_WIDTH-1:0] i_q_max,
  input  logic                  i_reward_valid,
  input  logic [DATA_WIDTH-1:0] i_reward,
  input  logic                  i_done,
  output logic [DATA_WIDTH-1:0] o_loss_value,
  output logic                  o_loss_value_valid
);

  logic [DATA_WIDTH-1:0] r_reward;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_reward_sel;
  logic                  w_done_sel;
  logic [3:1]            r_vld_pipe;
  logic [3:1]            r_done_pipe;
  logic [DATA_WIDTH-1:0] r_reward_pipe [1:3];
  logic                  r_sel_done;
  logic [DATA_WIDTH-1:0] r_sel_reward;
  logic                  w_mac_valid;
  logic [DATA_WIDTH-1:0] w_mac_result;

  // A reward arriving with the Q-max strobe takes precedence over the latch
  assign w_reward_sel = i_reward_valid ? i_reward : r_reward;
  assign w_done_sel = i_reward_valid ? i_done : r_done;

  // Capture the latest reward/done; a newer strobe simply overwrites
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reward <= '0;
      r_done <= 1'b0;
    end else if (i_reward_valid) begin
      r_reward <= i_reward;
      r_done <= i_done;
    end
  end

  // Carry the launch's reward/done beside the arithmetic for the terminal bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_done_pipe <= '0;
      for (int i = 1; i <= 3; i++) begin
        r_reward_pipe[i] <= '0;
      end
      r_sel_done <= 1'b0;
      r_sel_reward <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[2:1], i_q_max_valid};
      r_done_pipe <= {r_done_pipe[2:1], w_done_sel};
      r_reward_pipe[1] <= w_reward_sel;
      r_reward_pipe[2] <= r_reward_pipe[1];
      r_reward_pipe[3] <= r_reward_pipe[2];
      if (r_vld_pipe[3]) begin
        r_sel_done <= r_done_pipe[3];
        r_sel_reward <= r_reward_pipe[3];
      end
    end
  end

  fp32_mul_add u_mul_add (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_q_max_valid),
    .i_a      (GAMMA),
    .i_b      (i_q_max),
    .i_c      (w_reward_sel),
    .o_valid  (w_mac_valid),
    .o_result (w_mac_result)
  );

  // Both mux inputs are held registers, so the output holds between strobes
  assign o_loss_value = r_sel_done ? r_sel_reward : w_mac_result;
  assign o_loss_value_valid = w_mac_valid;

endmodule

// File: tb/tb_dqn_td_target_unit.sv
// Bench for dqn_td_target_unit: directed cases plus random traffic, checked
// each cycle against a real-number FP32 reference model.
module tb_dqn_td_target_unit;

  localparam logic [31:0] GAMMA_BITS = 32'h3F4CCCCD;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_q_max_valid = 1'b0;
  logic [31:0] i_q_max = '0;
  logic        i_reward_valid = 1'b0;
  logic [31:0] i_reward = '0;
  logic        i_done = 1'b0;
  logic [31:0] o_loss_value;
  logic        o_loss_value_valid;

  always #5 clk = ~clk;

  dqn_td_target_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_q_max_valid      (i_q_max_valid),
    .i_q_max            (i_q_max),
    .i_reward_valid     (i_reward_valid),
    .i_reward           (i_reward),
    .i_done             (i_done),
    .o_loss_value       (o_loss_value),
    .o_loss_value_valid (o_loss_value_valid)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        exp_v [0:DEPTH-1];
  logic [31:0] exp_y [0:DEPTH-1];
  logic [31:0] last_y = '0;
  logic [31:0] m_reward = '0;
  logic        m_done = 1'b0;

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real pow2(input int e);
    real p;
    p = 1.0;
    if (e >= 0) repeat (e) p = p * 2.0;
    else repeat (-e) p = p / 2.0;
    return p;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    m = m * pow2(e);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic        s;
    real         a, m, fr;
    int          e, be;
    longint      mi;
    logic [63:0] mb;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = a * 8388608.0;
    mi = longint'($floor(m));
    fr = m - $floor(m);
    if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
    if (mi == 64'd16777216) begin mi = 64'd8388608; e++; end
    be = e + 127;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be <= 0) return {s, 31'd0};
    mb = mi;
    return {s, be[7:0], mb[22:0]};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) || is_inf(b)) return (is_zero(a) || is_zero(b)) ? QNAN : {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    real v;
    if (is_nan(x) || is_nan(y)) return QNAN;
    if (is_inf(x) && is_inf(y)) return (x[31] == y[31]) ? x : QNAN;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    if (is_zero(x) && is_zero(y)) return {x[31] & y[31], 31'd0};
    if (is_zero(x)) return y;
    if (is_zero(y)) return x;
    v = f2r(x) + f2r(y);
    if (v == 0.0) return 32'h0;
    return r2f(v);
  endfunction

  function automatic logic [31:0] ref_y(input logic [31:0] r, input logic d, input logic [31:0] q);
    return d ? r : ref_add(ref_mul(GAMMA_BITS, q), r);
  endfunction

  function automatic logic [31:0] rand_fp(input int emin, input int emax);
    logic       s;
    logic [7:0] e;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(emin, emax));
    return {s, e, 23'($urandom)};
  endfunction

  // ---------------- per-cycle helpers ----------------
  task automatic check_outputs();
    checks++;
    assert (o_loss_value_valid === exp_v[cyc]) else begin
      errors++;
      $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, o_loss_value_valid, exp_v[cyc]);
    end
    if (exp_v[cyc]) last_y = exp_y[cyc];
    checks++;
    assert (o_loss_value === last_y) else begin
      errors++;
      $error("FAIL value cyc=%0d observed=%h expected=%h", cyc, o_loss_value, last_y);
    end
  endtask

  task automatic tick(input logic rv, input logic [31:0] r, input logic d,
                      input logic qv, input logic [31:0] q);
    logic [31:0] y;
    @(negedge clk);
    check_outputs();
    i_reward_valid = rv;
    i_reward = r;
    i_done = d;
    i_q_max_valid = qv;
    i_q_max = q;
    if (qv) begin
      y = rv ? ref_y(r, d, q) : ref_y(m_reward, m_done, q);
      exp_v[cyc + 4] = 1'b1;
      exp_y[cyc + 4] = y;
      $display("cyc=%0d launch reward=%h done=%b q_max=%h -> y=%h",
               cyc, rv ? r : m_reward, rv ? d : m_done, q, y);
    end
    if (rv) begin
      m_reward = r;
      m_done = d;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0;
    i_reward_valid = 1'b0;
    i_q_max_valid = 1'b0;
    i_reward = '0;
    i_q_max = '0;
    i_done = 1'b0;
    m_reward = '0;
    m_done = 1'b0;
    last_y = '0;
    for (int i = cyc + 1; i < DEPTH; i++) exp_v[i] = 1'b0;
    $display("cyc=%0d reset asserted", cyc);
    cyc++;
    repeat (n) begin
      @(negedge clk);
      check_outputs();
      cyc++;
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      exp_v[i] = 1'b0;
      exp_y[i] = '0;
    end
    // reset state
    idle(2);
    rst_n = 1'b1;
    idle(1);
    // Q-max with no prior reward uses 0 / not-done: y = 0.8*5 = 4.0
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h40A00000);
    idle(5);
    // non-terminal: reward 1.0, q_max 5.0 three cycles later -> 5.0
    tick(1'b1, 32'h3F800000, 1'b0, 1'b0, 32'h0);
    idle(2);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h40A00000);
    idle(5);
    // terminal: reward -1.0 done -> y = reward bits
    tick(1'b1, 32'hBF800000, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h40A00000);
    idle(5);
    // same cycle: latched 1.0 overridden by incoming 0, q -2.5 -> -2.0
    tick(1'b1, 32'h3F800000, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h00000000, 1'b0, 1'b1, 32'hC0200000);
    idle(5);
    // back-to-back launches
    tick(1'b1, 32'h3F800000, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h40A00000);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000000);
    idle(5);
    // reset two cycles after a launch discards it
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h40A00000);
    idle(1);
    apply_reset(3);
    idle(4);
    tick(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h40A00000);
    idle(5);
    // special values
    tick(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h7F800000);  // +inf
    tick(1'b1, 32'h3F800000, 1'b1, 1'b1, 32'h7F800000);  // done ignores inf
    tick(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h7F800001);  // NaN -> canonical
    tick(1'b1, 32'hC0800000, 1'b0, 1'b1, 32'h40A00000);  // 4 + -4 -> +0
    tick(1'b1, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF);  // overflow -> +inf
    tick(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h00000001);  // denormal q as zero
    tick(1'b1, 32'hFF800000, 1'b0, 1'b1, 32'h7F800000);  // inf - inf -> NaN
    idle(5);
    // random traffic, exponents kept close so the real-valued sum is exact
    for (int n = 0; n < 200; n++) begin
      logic        rv, d, qv;
      logic [31:0] r, q;
      rv = ($urandom_range(0, 2) == 0);
      qv = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 3) == 0);
      r = rand_fp(118, 136);
      q = rand_fp(120, 134);
      tick(rv, r, d, qv, q);
    end
    idle(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dqn_td_target_unit.md
Name: dqn_td_target_unit

Overview:
- Loss/target stage of the DQN training datapath.
- Latches the reward and the done flag of a training sample when the sample arrives. The target network's Q-max arrives some cycles later.
- On that arrival the block computes the TD target y = done ? reward : reward + GAMMA*q_max in IEEE-754 single precision.
- y is presented to the main network, which forms the loss (Q(s,a) − y) and backpropagates it.

Parameters:
- DATA_WIDTH, 32, float word width; only 32 is supported.
- GAMMA, 32'h3F4CCCCD (0.8), discount factor as an FP32 bit pattern.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_q_max_valid  input  1  one-cycle strobe; i_q_max is valid
- i_q_max  input  DATA_WIDTH  FP32 max Q of the next state (target net)
- i_reward_valid  input  1  one-cycle strobe; i_reward and i_done are valid
- i_reward  input  DATA_WIDTH  FP32 reward
- i_done  input  1  episode-terminal flag for the sample
- o_loss_value  output  DATA_WIDTH  FP32 TD target y
- o_loss_value_valid  output  1  one-cycle strobe; o_loss_value is valid

Behaviour:
- Reset (asynchronous, rst_n=0):
  - o_loss_value=0 and o_loss_value_valid=0.
  - Latched reward=0, latched done=0.
  - All pipeline valids cleared. Any in-flight result is discarded and never emitted.
- Capture: when i_reward_valid=1, register i_reward and i_done. A later strobe overwrites them; there is no queue.
- Launch: when i_q_max_valid=1, start a computation using the latched reward/done.
  - If i_reward_valid and i_q_max_valid are high in the same cycle, use the incoming i_reward/i_done, not the old latched values.
  - If i_q_max_valid arrives with no prior reward strobe, use the latched values (0 / not-done after reset).
- Latency: o_loss_value_valid rises exactly 4 cycles after the i_q_max_valid cycle, for 1 cycle.
  - Stages 1–2: FP32 multiply GAMMA*q_max.
  - Stages 3–4: FP32 add with reward.
  - Pipelined: one launch per cycle is accepted; results emerge in order.
- Done=1: the result is exactly the reward bits, with the same 4-cycle latency. The product is ignored.
- o_loss_value holds its last value while valid is low.
- Arithmetic:
  - Round to nearest, ties to even.
  - Denormal inputs are treated as zero; denormal results are flushed to signed zero.
  - Overflow gives ±infinity.
  - Inf/NaN operands produce the canonical NaN 32'h7FC00000 (inf·0, inf−inf) or propagate infinity per IEEE sign rules.
  - x + (−x) gives +0.
- Valid strobes wider than one cycle launch one computation per high cycle.

Decomposition:
- Shared package: FP32 field widths (sign 1, exponent 8, mantissa 23), bias 127, canonical NaN 32'h7FC00000, positive zero, default GAMMA 32'h3F4CCCCD.
- One sub-module: fp32_mul_add, a 4-stage unfused multiply-then-add (a*b + c) with a valid pipeline.
- The top holds the capture registers, the same-cycle bypass and the done-select mux delayed alongside the pipeline.

Test Plan:
- Non-terminal: reward 32'h3F800000 (1.0), done=0; 3 cycles later q_max 32'h40A00000 (5.0) → 4 cycles later y = 32'h40A00000 (5.0), valid high 1 cycle.
- Terminal: reward 32'hBF800000 (−1.0), done=1, q_max 32'h40A00000 → y = 32'hBF800000.
- Same-cycle: old reward 1.0 latched; new reward 0 with done=0 and q_max 32'hC0200000 (−2.5) in the same cycle → y = 32'hC0000000 (−2.0).
- Back-to-back: q_max strobes on consecutive cycles 5.0 then 0.0, reward 1.0, done=0 → results 32'h40A00000 then 32'h3F800000 on consecutive cycles.
- Reset mid-flight: assert rst_n=0 two cycles after a q_max strobe → valid never rises; outputs read 0. After release, a new sample computes correctly.
- Special values: q_max 32'h7F800000 (+inf), reward 1.0, done=0 → y = 32'h7F800000. Same q_max with done=1 → y = 32'h3F800000.
